cmd_issuer: RTL
===============

# cmd_issuer

Host-side initiator for the MunchMan UART command protocol. Serialises SET-hash, PROC-chars and RET-match commands onto a byte-wide UART transmitter, then parses the single-byte ACK/NACK or the return-data reply from the UART receiver. It sits between a local controller (test sequencer or board-to-board master) and a uart_tx/uart_rx pair, and lets one iCE40 drive a remote hash cruncher.

## Interface
- TIMEOUT_CYCLES, 24'd9_600_000: reply timeout (100 ms at 96 MHz); reloads on every received byte.
- RET_STR_LEN, 19: number of match-string bytes that follow the 2-byte position in a RET reply.
- clk_96mhz  in  1  system clock. One clock only; reset is asynchronous and active-high.
- reset  in  1  async active-high reset.
- txd_busy  in  1  UART transmitter busy.
- txd_start  out  1  one-cycle pulse that launches txd_data.
- txd_data  out  8  byte to transmit.
- rxd_data  in  8  received byte.
- rxd_data_ready  in  1  one-cycle strobe: rxd_data is valid.
- cmd_start  in  1  one-cycle request; ignored while cmd_busy.
- cmd_op  in  2  1=SET, 2=PROC, 3=RET, 0=invalid.
- cmd_hash  in  128  target hash; latched at cmd_start.
- cmd_num_bytes  in  16  PROC byte count; latched at cmd_start.
- src_data  in  8  PROC payload byte.
- src_valid  in  1  src_data is available.
- src_next  out  1  one-cycle pulse: src_data consumed.
- cmd_busy  out  1  high from the cycle after accepted cmd_start until the cycle after cmd_done.
- cmd_done  out  1  one-cycle completion pulse.
- cmd_ack  out  1  result, valid with cmd_done. ACK/match = 1.
- cmd_timeout  out  1  valid with cmd_done; 1 means the reply timed out.
- ret_byte_pos  out  16  RET match position; held until the next cmd_start.
- ret_data  out  8  RET string byte.
- ret_data_valid  out  1  one-cycle strobe per string byte.
- leds  out  8  current state encoding.

## Operation
- Reset: every output is 0. State goes to IDLE. The timeout counter and the latched hash and length clear to 0.
- States: IDLE, SEND_OP, SEND_HASH, SEND_LEN, SEND_DATA, WAIT_ACK, RECV_POS, RECV_STR, DONE.
- IDLE + cmd_start:
  - cmd_op=0: go to DONE with cmd_ack=0, cmd_timeout=0. Nothing is transmitted.
  - Otherwise: latch the inputs and go to SEND_OP.
- SEND_OP sends opcode 0x01, 0x02 or 0x03. It then goes to SEND_HASH (SET), SEND_LEN (PROC) or RECV_POS (RET).
- SEND_HASH: 16 bytes, hash[127:120] first, then to WAIT_ACK.
- SEND_LEN: 2 bytes, MSB first.
  - Then to SEND_DATA.
  - If num_bytes=0, go straight to WAIT_ACK.
- SEND_DATA: sends num_bytes bytes taken from src_data.
  - A byte is sent only when src_valid=1 and the transmitter is free; src_next pulses in the same cycle as txd_start.
  - src_valid low stalls the state indefinitely, with no timeout.
  - Then to WAIT_ACK.
- WAIT_ACK: the first byte received decides the result. 0x01 gives cmd_ack=1; any other value gives cmd_ack=0. Then to DONE.
- RECV_POS: 2 bytes, MSB first, into ret_byte_pos. Then to RECV_STR.
- RECV_STR: each of RET_STR_LEN bytes drives ret_data and pulses ret_data_valid. After the last byte, go to DONE with cmd_ack=1.
- Timeout (WAIT_ACK, RECV_POS, RECV_STR only): the counter reaching TIMEOUT_CYCLES-1 with no byte received goes to DONE with cmd_ack=0, cmd_timeout=1.
- DONE: pulse cmd_done for one cycle, then return to IDLE.
- rxd_data_ready outside the receive states: the byte is dropped.

## Timing
- Transmit rule:
  - Assert txd_start for exactly one cycle, only when txd_busy=0.
  - Ignore txd_busy during the cycle after a pulse (guard cycle), then wait for txd_busy=0.
  - Minimum spacing between pulses is therefore 2 cycles.
- The first txd_start fires 1 cycle after cmd_start, if txd_busy=0.
- rxd byte to ret_data_valid: 1 cycle, registered.
- Last reply byte to cmd_done: 2 cycles (state update, then DONE).
- A byte and the timeout arriving in the same cycle: the byte wins.
- Async reset mid-command aborts immediately. No partial cmd_done is produced.

## Structure
- Package cmd_proto_pkg holds:
  - SET_CMD=0x01, PROC_CMD=0x02, RET_CMD=0x03, ACK_CHAR=0x01, NACK_CHAR=0x00.
  - The 8-bit state encodings.
  - This block and the FPGA-side parser share the package.
- One sub-module, tx_byte_sender, owns the start-pulse/guard-cycle handshake. It exposes byte_valid, byte_data and byte_taken.
- The byte counter is 16 bits and the timeout counter is 24 bits.

## Test plan
- SET, hash 0x00112233…EEFF, responder replies 0x01 → TX 01 00 11 … FF (17 bytes); cmd_done with cmd_ack=1, cmd_timeout=0.
- PROC, num_bytes=3, src bytes 'a' 'b' 'c' with src_valid dropped for 10 cycles mid-stream, reply 0x00 → TX 02 00 03 61 62 63; src_next pulses 3 times; cmd_ack=0.
- RET, reply 01 2C followed by 19 bytes 0x41..0x53 → ret_byte_pos=0x012C; 19 ret_data_valid pulses in order; cmd_ack=1.
- SET with no reply, TIMEOUT_CYCLES=100 → cmd_done 100 cycles after the last TX byte; cmd_timeout=1, cmd_ack=0.
- Reset asserted during the 5th hash byte → all outputs 0 immediately; the next SET runs cleanly from the opcode.
- cmd_op=0 → cmd_done 2 cycles after cmd_start, no txd_start; a cmd_start while busy is ignored.

Source files
------------

// File: rtl/cmd_proto_pkg.sv
// cmd_proto_pkg: shared definitions for the MunchMan UART command protocol.
// Used by the host-side cmd_issuer and by the FPGA-side command parser.
//   - command opcodes and reply characters
//   - 2-bit host operation codes presented on cmd_op
//   - 8-bit FSM state encodings (also shown on the leds)
package cmd_proto_pkg;

    localparam logic [7:0] SET_CMD   = 8'h01;
    localparam logic [7:0] PROC_CMD  = 8'h02;
    localparam logic [7:0] RET_CMD   = 8'h03;
    localparam logic [7:0] ACK_CHAR  = 8'h01;
    localparam logic [7:0] NACK_CHAR = 8'h00;

    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_SET  = 2'd1;
    localparam logic [1:0] OP_PROC = 2'd2;
    localparam logic [1:0] OP_RET  = 2'd3;

    typedef enum logic [7:0] {
        ST_IDLE      = 8'h00,
        ST_SEND_OP   = 8'h01,
        ST_SEND_HASH = 8'h02,
        ST_SEND_LEN  = 8'h03,
        ST_SEND_DATA = 8'h04,
        ST_WAIT_ACK  = 8'h05,
        ST_RECV_POS  = 8'h06,
        ST_RECV_STR  = 8'h07,
        ST_DONE      = 8'h08
    } state_t;

    // Wire opcode for a host operation code (OP_NONE is never transmitted).
    function automatic logic [7:0] opcode_byte(input logic [1:0] op);
        case (op)
            OP_SET:  return SET_CMD;
            OP_PROC: return PROC_CMD;
            default: return RET_CMD;
        endcase
    endfunction

endpackage

// File: rtl/tx_byte_sender.sv
// tx_byte_sender: start-pulse / guard-cycle handshake towards a uart_tx.
//   clk, rst     : clock, asynchronous active-high reset
//   txd_busy     : transmitter busy
//   byte_valid   : a byte is offered on byte_data
//   byte_data    : byte to send
//   byte_taken   : one-cycle pulse, byte_data launched this cycle
//   txd_start    : one-cycle start pulse to the transmitter
//   txd_data     : byte to the transmitter
module tx_byte_sender (
    input  logic       clk,
    input  logic       rst,
    input  logic       txd_busy,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_taken,
    output logic       txd_start,
    output logic [7:0] txd_data
);

    // The transmitter may only raise busy one cycle after a start pulse, so
    // the cycle right after a pulse is blocked regardless of txd_busy.
    logic guard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            guard <= 1'b0;
        end else begin
            guard <= txd_start;
        end
    end

    assign txd_start  = byte_valid && !guard && !txd_busy;
    assign byte_taken = txd_start;
    assign txd_data   = byte_data;

endmodule

// File: rtl/cmd_issuer.sv
// cmd_issuer: host-side initiator for the MunchMan UART command protocol.
// Sends SET / PROC / RET commands through a uart_tx and parses the reply
// from a uart_rx.
//   clk_96mhz, reset      : clock, asynchronous active-high reset
//   txd_*                 : byte-wide transmitter handshake
//   rxd_*                 : received byte and its strobe
//   cmd_start/op/hash/num_bytes : command request (latched on acceptance)
//   src_data/valid/next   : PROC payload source
//   cmd_busy/done/ack/timeout   : command status and result
//   ret_byte_pos, ret_data, ret_data_valid : RET reply contents
//   leds                  : current state encoding
module cmd_issuer
    import cmd_proto_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd9_600_000,
    parameter int unsigned RET_STR_LEN    = 19
) (
    input  logic         clk_96mhz,
    input  logic         reset,
    input  logic         txd_busy,
    output logic         txd_start,
    output logic [7:0]   txd_data,
    input  logic [7:0]   rxd_data,
    input  logic         rxd_data_ready,
    input  logic         cmd_start,
    input  logic [1:0]   cmd_op,
    input  logic [127:0] cmd_hash,
    input  logic [15:0]  cmd_num_bytes,
    input  logic [7:0]   src_data,
    input  logic         src_valid,
    output logic         src_next,
    output logic         cmd_busy,
    output logic         cmd_done,
    output logic         cmd_ack,
    output logic         cmd_timeout,
    output logic [15:0]  ret_byte_pos,
    output logic [7:0]   ret_data,
    output logic         ret_data_valid,
    output logic [7:0]   leds
);

    localparam logic [15:0] STR_LAST = 16'(RET_STR_LEN - 1);
    localparam logic [23:0] TMO_LAST = TIMEOUT_CYCLES - 24'd1;

    state_t       state;
    logic [1:0]   op_q;
    logic [127:0] hash_q;
    logic [15:0]  len_q;
    logic [15:0]  cnt;
    logic [23:0]  tmo;
    logic         res_ack;
    logic         res_tmo;

    logic         byte_valid;
    logic [7:0]   byte_data;
    logic         byte_taken;

    tx_byte_sender u_tx (
        .clk        (clk_96mhz),
        .rst        (reset),
        .txd_busy   (txd_busy),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_taken (byte_taken),
        .txd_start  (txd_start),
        .txd_data   (txd_data)
    );

    // Byte offered to the sender in each transmit state.
    always_comb begin
        byte_valid = 1'b0;
        byte_data  = '0;
        case (state)
            ST_SEND_OP: begin
                byte_valid = 1'b1;
                byte_data  = opcode_byte(op_q);
            end
            ST_SEND_HASH: begin
                byte_valid = 1'b1;
                byte_data  = hash_q[127:120];
            end
            ST_SEND_LEN: begin
                byte_valid = 1'b1;
                byte_data  = (cnt == 16'd0) ? len_q[15:8] : len_q[7:0];
            end
            ST_SEND_DATA: begin
                byte_valid = src_valid;
                byte_data  = src_data;
            end
            default: ;
        endcase
    end

    assign src_next = byte_taken && (state == ST_SEND_DATA);
    assign leds     = state;

    always_ff @(posedge clk_96mhz or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            op_q           <= '0;
            hash_q         <= '0;
            len_q          <= '0;
            cnt            <= '0;
            tmo            <= '0;
            res_ack        <= 1'b0;
            res_tmo        <= 1'b0;
            cmd_busy       <= 1'b0;
            cmd_done       <= 1'b0;
            cmd_ack        <= 1'b0;
            cmd_timeout    <= 1'b0;
            ret_byte_pos   <= '0;
            ret_data       <= '0;
            ret_data_valid <= 1'b0;
        end else begin
            cmd_done       <= 1'b0;
            cmd_ack        <= 1'b0;
            cmd_timeout    <= 1'b0;
            ret_data_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // cmd_busy stays high through the cmd_done cycle, so a
                    // request in that cycle is ignored as well.
                    if (cmd_start && !cmd_busy) begin
                        cmd_busy     <= 1'b1;
                        ret_byte_pos <= '0;
                        cnt          <= '0;
                        tmo          <= '0;
                        if (cmd_op == OP_NONE) begin
                            res_ack <= 1'b0;
                            res_tmo <= 1'b0;
                            state   <= ST_DONE;
                        end else begin
                            op_q   <= cmd_op;
                            hash_q <= cmd_hash;
                            len_q  <= cmd_num_bytes;
                            state  <= ST_SEND_OP;
                        end
                    end else begin
                        cmd_busy <= 1'b0;
                    end
                end

                ST_SEND_OP: begin
                    if (byte_taken) begin
                        case (op_q)
                            OP_SET:  state <= ST_SEND_HASH;
                            OP_PROC: state <= ST_SEND_LEN;
                            default: state <= ST_RECV_POS;
                        endcase
                    end
                end

                ST_SEND_HASH: begin
                    if (byte_taken) begin
                        hash_q <= {hash_q[119:0], 8'h00};
                        if (cnt == 16'd15) begin
                            cnt   <= '0;
                            state <= ST_WAIT_ACK;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end

                ST_SEND_LEN: begin
                    if (byte_taken) begin
                        if (cnt == 16'd1) begin
                            cnt   <= '0;
                            state <= (len_q == 16'd0) ? ST_WAIT_ACK : ST_SEND_DATA;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end

                ST_SEND_DATA: begin
                    if (byte_taken) begin
                        if (cnt == len_q - 16'd1) begin
                            cnt   <= '0;
                            state <= ST_WAIT_ACK;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end

                // In the receive states a byte always takes priority over
                // the timeout; tmo restarts on every byte.
                ST_WAIT_ACK: begin
                    if (rxd_data_ready) begin
                        res_ack <= (rxd_data == ACK_CHAR);
                        res_tmo <= 1'b0;
                        state   <= ST_DONE;
                    end else if (tmo == TMO_LAST) begin
                        res_ack <= 1'b0;
                        res_tmo <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        tmo <= tmo + 24'd1;
                    end
                end

                ST_RECV_POS: begin
                    if (rxd_data_ready) begin
                        tmo <= '0;
                        if (cnt == 16'd0) begin
                            ret_byte_pos[15:8] <= rxd_data;
                            cnt                <= 16'd1;
                        end else begin
                            ret_byte_pos[7:0] <= rxd_data;
                            cnt               <= '0;
                            state             <= ST_RECV_STR;
                        end
                    end else if (tmo == TMO_LAST) begin
                        res_ack <= 1'b0;
                        res_tmo <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        tmo <= tmo + 24'd1;
                    end
                end

                ST_RECV_STR: begin
                    if (rxd_data_ready) begin
                        tmo            <= '0;
                        ret_data       <= rxd_data;
                        ret_data_valid <= 1'b1;
                        if (cnt == STR_LAST) begin
                            cnt     <= '0;
                            res_ack <= 1'b1;
                            res_tmo <= 1'b0;
                            state   <= ST_DONE;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end else if (tmo == TMO_LAST) begin
                        res_ack <= 1'b0;
                        res_tmo <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        tmo <= tmo + 24'd1;
                    end
                end

                ST_DONE: begin
                    cmd_done    <= 1'b1;
                    cmd_ack     <= res_ack;
                    cmd_timeout <= res_tmo;
                    state       <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
